// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front end: access size codes, FSM states
// and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    RSP     = 3'd3,
    ERR_RSP = 3'd4
  } state_t;

  // The reserved size code is reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane logic: extracts and extends a load value from a RAM word and
// merges sub-word store data into it.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shamt;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_mask;

  always_comb begin
    w_shamt = {i_offset, 3'b000};
    w_half  = 16'(i_word >> w_shamt);
    w_byte  = w_half[7:0];
    o_load  = i_word;
    w_mask  = 32'hFFFF_FFFF;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        w_mask = 32'h0000_00FF << w_shamt;
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        w_mask = 32'h0000_FFFF << w_shamt;
      end
      default: ;
    endcase
    o_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end and sole master of the 128x32 word RAM: drives CS/WE/ADDR and
// the shared tristate bus, with read-modify-write for byte and halfword stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [31:0]       Mem_Bus
);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        r_drv_en;
  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_wbus;
  logic [31:0] r_load;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign Mem_Bus   = r_drv_en ? r_wbus : 32'hZZZZ_ZZZZ;

  mem_lane_merge u_lane (
    .i_word   (Mem_Bus),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0]))   w_next = ERR_RSP;
          else if (req_we && req_size == SZ_WORD)    w_next = WR;
          else                                       w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : RSP;
      WR:      w_next = RSP;
      RSP:     w_next = IDLE;
      ERR_RSP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pin and response registers follow the next state so the RAM sees CS/WE for the
  // whole cycle the FSM spends in RD/WR; the response trails the RSP state by one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      CS        <= 1'b0;
      WE        <= 1'b0;
      r_drv_en  <= 1'b0;
      ADDR      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state   <= w_next;
      CS        <= (w_next == RD) || (w_next == WR);
      WE        <= (w_next == WR);
      r_drv_en  <= (w_next == WR);
      rsp_valid <= (r_state == RSP) || (r_state == ERR_RSP);
      rsp_err   <= (r_state == ERR_RSP);
      rsp_rdata <= (r_state == RSP && !r_we) ? r_load : '0;
      if (w_accept) ADDR <= req_addr[ADDR_W+1:2];
    end
  end

  // Request fields and datapath words carry no reset; they are only consumed under
  // the state control above.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_off    <= req_addr[1:0];
      r_wdata  <= req_wdata;
      r_wbus   <= req_wdata;
    end else if (r_state == RD) begin
      r_load   <= w_load;
      r_wbus   <= w_merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 128x32 falling-edge RAM on the shared bus, directed
// scenarios and random traffic checked against a byte-array reference memory.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        CS, WE;
  logic [6:0]  ADDR;
  wire  [31:0] mem_bus;

  logic [31:0] ram  [128];
  logic [7:0]  rmem [512];

  int n_pass = 0, n_chk = 0;
  int viol = 0, rsp_cnt = 0, cs_cnt = 0, acc_cnt = 0;
  logic [31:0] last_rd;

  mem_access_unit #(.ADDR_W(7)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(mem_bus)
  );

  always #5 CLK = ~CLK;

  // RAM: drives the bus only when selected for reading, writes on the falling edge.
  assign mem_bus = (CS && !WE) ? ram[ADDR] : 32'hZZZZ_ZZZZ;
  always @(negedge CLK) if (CS && WE) ram[ADDR] <= mem_bus;

  always @(posedge CLK) begin
    if (CS && req_ready) viol++;
    if (WE && !CS) viol++;
    if (rsp_valid) rsp_cnt++;
    if (CS) cs_cnt++;
    if (req_valid && req_ready) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [8:0] a);
    if (sz == 2'b11) return 1'b1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] sz, input logic sg);
    int nb = 1 << sz;
    logic [31:0] v = '0;
    for (int k = 0; k < nb; k++) v |= 32'(rmem[int'(a) + k]) << (8 * k);
    if (sg && nb < 4 && v[8*nb-1]) v |= ~((32'h1 << (8 * nb)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
  endfunction

  task automatic ref_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) rmem[int'(a) + k] = wd[8*k +: 8];
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd, input string tag);
    logic        err;
    logic [31:0] exp_rd;
    int          exp_lat, lat, t, cs0;
    err     = ref_err(sz, a);
    exp_rd  = (!err && !we) ? ref_load(a, sz, sg) : 32'h0;
    exp_lat = err ? 1 : ((we && sz != 2'b10) ? 3 : 2);
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge CLK); t++; end
    if (!req_ready) begin
      chk({tag, "_ready"}, 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    cs0 = cs_cnt;
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;
    lat = 0;
    while (lat < 10) begin
      @(posedge CLK); #1; lat++;
      if (rsp_valid) break;
    end
    last_rd = rsp_rdata;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(rsp_err), 32'(err));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    if (err) chk({tag, "_cs"}, 32'(cs_cnt - cs0), 32'h0);
    if (we && !err) ref_store(a, sz, wd);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_q [$];
    int bad, c0, r0;

    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 128; w++) begin
      v = $urandom;
      ram[w] = v;
      for (int k = 0; k < 4; k++) rmem[4*w+k] = v[8*k +: 8];
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cs", 32'(CS), 32'h0);
    chk("rst_we", 32'(WE), 32'h0);
    chk("rst_addr", 32'(ADDR), 32'h0);
    chk("rst_vld", 32'(rsp_valid), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ready", 32'(req_ready), 32'h1);

    // word store then load
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, "st_w");
    chk("ram4_w", ram[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, "ld_w");
    chk("ld_w_val", last_rd, 32'hDEADBEEF);

    // extension
    do_req(1'b0, 2'b00, 1'b1, 9'h013, 32'h0, "ld_sb");
    chk("ld_sb_val", last_rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b0, 9'h013, 32'h0, "ld_ub");
    chk("ld_ub_val", last_rd, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b1, 9'h010, 32'h0, "ld_sh");
    chk("ld_sh_val", last_rd, 32'hFFFFBEEF);

    // sub-word read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 9'h011, 32'hFFFFFF12, "st_b");
    chk("ram4_b", ram[4], 32'hDEAD12EF);
    do_req(1'b1, 2'b01, 1'b0, 9'h012, 32'hABCD3456, "st_h");
    chk("ram4_h", ram[4], 32'h345612EF);

    // misaligned and reserved-size requests
    do_req(1'b0, 2'b01, 1'b1, 9'h011, 32'h0, "e_half");
    do_req(1'b1, 2'b10, 1'b0, 9'h012, 32'h11111111, "e_word");
    do_req(1'b0, 2'b11, 1'b0, 9'h010, 32'h0, "e_rsvd");
    chk("ram4_err", ram[4], 32'h345612EF);

    // back-to-back loads with req_valid held high
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_load(9'(9'h040 + 4*i), 2'b10, 1'b0));
    c0 = acc_cnt;
    fork
      begin
        @(negedge CLK);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          int c, t;
          req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
          req_addr = 9'(9'h040 + 4*i); req_wdata = '0;
          c = acc_cnt; t = 0;
          do begin @(negedge CLK); t++; end while (acc_cnt == c && t < 20);
        end
        req_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int t = 0;
          do begin @(posedge CLK); #1; t++; end while (!rsp_valid && t < 20);
          chk($sformatf("b2b_%0d", i), rsp_rdata, exp_q[i]);
        end
      end
    join
    repeat (3) @(posedge CLK);
    chk("b2b_accepts", 32'(acc_cnt - c0), 32'h3);

    // reset in the middle of a word store
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 9'h020; req_wdata = 32'hCAFEF00D;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    chk("mid_we", 32'(WE), 32'h1);
    r0 = rsp_cnt;
    RST_N = 1'b0;
    #1;
    chk("mid_cs", 32'(CS), 32'h0);
    chk("mid_we_drop", 32'(WE), 32'h0);
    repeat (4) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    chk("mid_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    chk("mid_ram8", ram[8], ref_word(8));
    @(negedge CLK);
    chk("mid_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, "mid_ld");

    // random traffic over a small window so stores and loads overlap
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), 9'($urandom_range(0, 63)), $urandom,
             $sformatf("rnd%0d", i));
    end

    bad = 0;
    for (int w = 0; w < 128; w++) if (ram[w] !== ref_word(w)) bad++;
    chk("ram_image", 32'(bad), 32'h0);
    chk("protocol", 32'(viol), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
